// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Instruction prefetcher placed in front of the CPU instruction port. It
// issues pipelined Avalon-MM reads for sequential words, buffers the returned
// words in an in-order FIFO and presents instruction + PC to the consumer
// over a valid/ready handshake. A redirect flushes the FIFO, restarts fetch
// at the new PC and discards every response still in flight.
//
// Parameters:
//   DEPTH     FIFO entries and maximum outstanding reads (power of two, >=2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   redirect, redirect_pc    flush and restart fetch at redirect_pc & ~3
//   out_valid/out_ready      consumer handshake
//   out_instr, out_pc        word at the FIFO head and its address
//   mem_address, mem_read    Avalon read request (held while waitrequest)
//   mem_waitrequest          agent stall
//   mem_readdatavalid/data   in-order read responses
//   mem_byteenable           constant 4'b1111
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty (and nothing
//   is being dropped or redirected) is presented combinationally in the same
//   cycle; it is consumed without a FIFO write when out_ready is high.
// ---------------------------------------------------------------------------
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata,
    output logic [3:0]  mem_byteenable
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fifo_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [31:0]   fetch_pc;
    logic [31:0]   out_pc_q;
    // A redirect that lands on a stalled request is parked here until the
    // old request is accepted, so the Avalon address stays stable.
    logic [31:0]   redir_pc;
    logic          redir_pend;

    logic          credit_ok;
    logic          accept;
    logic          rsp;
    logic          rsp_keep;
    logic          bypass;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic          consume;
    logic [CW-1:0] out_nxt;
    logic [31:0]   new_pc;

    assign new_pc = {redirect_pc[31:2], 2'b00};

    // Responses decrement outstanding while pushing, so occupancy+outstanding
    // bounds the FIFO fill and a full FIFO can never receive a response.
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);

    assign mem_read       = rst & (credit_ok | redir_pend);
    assign mem_address    = fetch_pc;
    assign mem_byteenable = 4'b1111;

    assign accept   = mem_read & ~mem_waitrequest;
    assign rsp      = mem_readdatavalid;
    assign rsp_keep = rsp & (drop == '0) & ~redirect;
    assign out_nxt  = outstanding + CW'(accept) - CW'(rsp);

`ifdef PREFETCH_BYPASS_EN
    assign bypass      = (count == '0) & rsp_keep;
    assign bypass_take = bypass & out_ready;
    assign out_instr   = (count == '0) ? mem_readdata : fifo_q[rd_ptr];
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
    assign out_instr   = fifo_q[rd_ptr];
`endif

    assign out_valid = (count != '0) | bypass;
    assign out_pc    = out_pc_q;
    assign push      = rsp_keep & ~bypass_take;
    assign pop       = (count != '0) & out_ready & ~redirect;
    assign consume   = pop | bypass_take;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= mem_readdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            fetch_pc    <= RESET_PC;
            out_pc_q    <= RESET_PC;
            redir_pc    <= RESET_PC;
            redir_pend  <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                // Every read issued up to and including this cycle is stale.
                drop     <= out_nxt;
                out_pc_q <= new_pc;
                if (mem_read && mem_waitrequest) begin
                    redir_pend <= 1'b1;
                    redir_pc   <= new_pc;
                end else begin
                    redir_pend <= 1'b0;
                    fetch_pc   <= new_pc;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if (consume) begin
                    out_pc_q <= out_pc_q + 32'd4;
                end
                // The parked stale request joins the drop count once accepted.
                drop <= drop - CW'(rsp && (drop != '0)) + CW'(accept && redir_pend);
                if (accept) begin
                    if (redir_pend) begin
                        fetch_pc   <= redir_pc;
                        redir_pend <= 1'b0;
                    end else begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
            end
        end
    end

    // A response with nothing outstanding is an interconnect protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_without_read: assert (!(mem_readdatavalid && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] K     = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;
    logic [3:0]  mem_byteenable;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .mem_address(mem_address), .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .mem_readdata(mem_readdata), .mem_byteenable(mem_byteenable)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int unsigned i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // Reference model: reads in flight (with a stale flag), words ready for
    // the consumer, and the address the current stream must fetch next.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } rd_t;

    rd_t         outq[$];
    logic [31:0] mfifo[$];
    logic [31:0] exp_fetch;
    bit          held_stale;
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] acc_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_ins[$];

    // Memory responder knobs
    int unsigned wait_pct = 0;
    int unsigned rsp_pct  = 100;
    bit          stall_en = 0;
    logic [31:0] stall_addr = '0;

    initial begin
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_waitrequest = (stall_en && mem_address == stall_addr) ||
                              ($urandom_range(99) < wait_pct);
            if (rst && outq.size() > 0 && $urandom_range(99) < rsp_pct) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = outq[0].addr ^ K;
            end else begin
                mem_readdatavalid = 1'b0;
                mem_readdata      = $urandom;
            end
        end
    end

    // Compare process: check outputs against the model, then advance it.
    always @(negedge clk) begin
        rd_t r;
        bit  acc;
        bit  pop;
        bit  have_r;
        if (!rst) begin
            chk("reset_mem_read", 32'(mem_read), 32'd0);
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            outq.delete();
            mfifo.delete();
            exp_fetch  = 32'h0;
            held_stale = 0;
            prev_stall = 0;
            prev_addr  = '0;
        end else begin
            chk("mem_read", 32'(mem_read),
                32'(prev_stall || (mfifo.size() + outq.size() < DEPTH)));
            if (prev_stall) chk("addr_hold", mem_address, prev_addr);
            chk("out_valid", 32'(out_valid), 32'(mfifo.size() != 0));
            if (mfifo.size() != 0) begin
                chk("out_pc", out_pc, mfifo[0]);
                chk("out_instr", out_instr, mfifo[0] ^ K);
            end
            chk("byteenable", 32'(mem_byteenable), 32'hF);
            acc = mem_read && !mem_waitrequest;
            pop = out_valid && out_ready;
            if (acc && !held_stale) chk("fetch_addr", mem_address, exp_fetch);

            have_r = 0;
            if (mem_readdatavalid) begin
                if (outq.size() == 0) chk("rsp_underflow", 32'd1, 32'd0);
                else begin
                    r = outq.pop_front();
                    have_r = 1;
                end
            end

            if (redirect) begin
                mfifo.delete();
                foreach (outq[i]) outq[i].stale = 1;
                if (acc) begin
                    outq.push_back('{mem_address, 1'b1});
                    acc_log.push_back(mem_address);
                end
                held_stale = mem_read && mem_waitrequest;
                exp_fetch  = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop && mfifo.size() != 0) begin
                    del_pc.push_back(mfifo[0]);
                    del_ins.push_back(out_instr);
                    void'(mfifo.pop_front());
                end
                if (have_r && !r.stale) mfifo.push_back(r.addr);
                if (acc) begin
                    outq.push_back('{mem_address, held_stale});
                    acc_log.push_back(mem_address);
                    if (!held_stale) exp_fetch = exp_fetch + 32'd4;
                    held_stale = 0;
                end
            end
            prev_stall = mem_read && mem_waitrequest;
            prev_addr  = mem_address;
        end
    end

    task automatic step(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst      = 1'b0;
        redirect = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    int unsigned a0;
    int unsigned d0;
    bit          found;

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;

        // Streaming with zero-wait memory
        out_ready = 1'b1;
        do_reset();
        a0 = acc_log.size();
        d0 = del_pc.size();
        step(12);
        chk("t1_acc0", at(acc_log, a0), 32'h0);
        chk("t1_acc1", at(acc_log, a0 + 1), 32'h4);
        chk("t1_acc2", at(acc_log, a0 + 2), 32'h8);
        chk("t1_pc0", at(del_pc, d0), 32'h0);
        chk("t1_ins0", at(del_ins, d0), 32'hA5A5_A5A5);
        chk("t1_pc1", at(del_pc, d0 + 1), 32'h4);
        chk("t1_ins1", at(del_ins, d0 + 1), 32'hA5A5_A5A1);
        chk("t1_rate", del_pc.size() - d0, 32'd10);

        // Consumer stalled: credit limit
        out_ready = 1'b0;
        do_reset();
        a0 = acc_log.size();
        d0 = del_pc.size();
        step(10);
        @(negedge clk);
        chk("t2_accepts", acc_log.size() - a0, 32'd4);
        chk("t2_mem_read", 32'(mem_read), 32'd0);
        step();
        out_ready = 1'b1;
        step(10);
        chk("t2_pc0", at(del_pc, d0), 32'h0);
        chk("t2_pc1", at(del_pc, d0 + 1), 32'h4);
        chk("t2_pc2", at(del_pc, d0 + 2), 32'h8);
        chk("t2_pc3", at(del_pc, d0 + 3), 32'hC);
        chk("t2_resume", at(acc_log, a0 + 4), 32'h10);

        // Redirect with reads in flight
        rsp_pct = 0;
        do_reset();
        a0 = acc_log.size();
        d0 = del_pc.size();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (outq.size() == 3) begin
                found = 1;
                break;
            end
        end
        chk("t3_reach_3_outstanding", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        rsp_pct  = 100;
        @(negedge clk);
        chk("t3_next_addr", mem_address, 32'h100);
        step(20);
        chk("t3_first_new_acc", at(acc_log, a0 + 4), 32'h100);
        chk("t3_first_pc", at(del_pc, d0), 32'h100);
        chk("t3_first_ins", at(del_ins, d0), 32'hA5A5_A4A5);

        // Redirect while a request is stalled
        stall_addr = 32'h8;
        stall_en   = 1;
        do_reset();
        a0 = acc_log.size();
        d0 = del_pc.size();
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_read && mem_waitrequest && mem_address == 32'h8) begin
                found = 1;
                break;
            end
        end
        chk("t4_stall_seen", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        stall_en = 0;
        step(20);
        chk("t4_acc2", at(acc_log, a0 + 2), 32'h8);
        chk("t4_acc3", at(acc_log, a0 + 3), 32'h40);
        chk("t4_first_pc", at(del_pc, d0), 32'h40);
        chk("t4_first_ins", at(del_ins, d0), 32'hA5A5_A5E5);

        // Redirect coincident with a response and a pop
        do_reset();
        step(6);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk("t5_coincident", {30'd0, out_valid, mem_readdatavalid}, 32'd3);
        step();
        redirect = 1'b0;
        d0 = del_pc.size();
        @(negedge clk);
        chk("t5_flushed", 32'(out_valid), 32'd0);
        step(15);
        chk("t5_first_pc", at(del_pc, d0), 32'h200);

        // Address wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        a0 = acc_log.size();
        d0 = del_pc.size();
        step(15);
        chk("t6_acc0", at(acc_log, a0), 32'hFFFF_FFF8);
        chk("t6_acc1", at(acc_log, a0 + 1), 32'hFFFF_FFFC);
        chk("t6_acc2", at(acc_log, a0 + 2), 32'h0);
        chk("t6_pc0", at(del_pc, d0), 32'hFFFF_FFF8);
        chk("t6_pc1", at(del_pc, d0 + 1), 32'hFFFF_FFFC);
        chk("t6_pc2", at(del_pc, d0 + 2), 32'h0);
        chk("t6_ins2", at(del_ins, d0 + 2), 32'hA5A5_A5A5);

        // Randomized traffic
        wait_pct = 30;
        rsp_pct  = 60;
        d0 = del_pc.size();
        for (int i = 0; i < 3000; i++) begin
            out_ready   = 1'($urandom_range(1));
            redirect    = ($urandom_range(99) < 3);
            redirect_pc = $urandom;
            step();
        end
        redirect  = 1'b0;
        out_ready = 1'b1;
        wait_pct  = 0;
        rsp_pct   = 100;
        step(30);
        chk("rand_progress", 32'(del_pc.size() - d0 > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
